// File: rtl/mem_responder_if.sv
// mem_responder_if: valid/ready request and response channels between an initiator and mem_responder.
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata, rsp_data;
  modport master (output req_valid, req_we, req_addr, req_wdata, rsp_ready,
                  input req_ready, rsp_valid, rsp_data, rsp_we);
  modport slave (input req_valid, req_we, req_addr, req_wdata, rsp_ready,
                 output req_ready, rsp_valid, rsp_data, rsp_we);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory serving one valid/ready request at a time.
// Define MEM_RESPONDER_CLEAR_EN to zero the whole storage after every reset.
module mem_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  mem_responder_if.slave bus,
  output logic busy
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
`ifdef MEM_RESPONDER_CLEAR_EN
  localparam logic [1:0] CLEAR = 2'd3;
  logic [ADDR_W-1:0] clr_addr;
`endif
  logic [1:0] state;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr_q, mem_wa;
  logic we_q, acc, mem_we;
  logic [DATA_W-1:0] wdata_q, mem_wd;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_comb begin
    acc = state == WAIT && cnt == 4'd1;
`ifdef MEM_RESPONDER_CLEAR_EN
    mem_we = reset && (state == CLEAR || (acc && we_q));
    mem_wa = state == CLEAR ? clr_addr : addr_q;
    mem_wd = state == CLEAR ? '0 : wdata_q;
`else
    mem_we = reset && acc && we_q;
    mem_wa = addr_q;
    mem_wd = wdata_q;
`endif
  end
  always_ff @(posedge clk)
    if (mem_we) mem[mem_wa] <= mem_wd;
  always_ff @(posedge clk)
    if (!reset) begin
`ifdef MEM_RESPONDER_CLEAR_EN
      state <= CLEAR;
      clr_addr <= '0;
`else
      state <= IDLE;
`endif
      cnt <= '0;
      bus.rsp_data <= '0;
      bus.rsp_we <= 1'b0;
    end else
      case (state)
        IDLE:
          if (bus.req_valid) begin
            addr_q <= bus.req_addr;
            we_q <= bus.req_we;
            wdata_q <= bus.req_wdata;
            cnt <= 4'(LATENCY);
            state <= WAIT;
          end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (acc) begin
            bus.rsp_data <= we_q ? wdata_q : mem[addr_q];
            bus.rsp_we <= we_q;
            state <= RESP;
          end
        end
        RESP:
          if (bus.rsp_ready) state <= IDLE;
        default: begin
`ifdef MEM_RESPONDER_CLEAR_EN
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) state <= IDLE;
`else
          state <= IDLE;
`endif
        end
      endcase
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench; instance 0 has LATENCY=2, instance 1 has LATENCY=1.
module tb_mem_responder;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int checks = 0, fails = 0;
  int lat[2] = '{2, 1};
  logic rv[2], rwe[2], rr[2];
  logic [3:0] ra[2];
  logic [15:0] rwd[2];
  logic qrdy[2], qval[2], qwe[2], qbusy[2];
  logic [15:0] qdata[2];
  logic [15:0] model[2][16];
  bit known[2][16];
  mem_responder_if #(.DATA_W(16), .ADDR_W(4)) b0 (), b1 ();
  assign b0.req_valid = rv[0];
  assign b0.req_we = rwe[0];
  assign b0.req_addr = ra[0];
  assign b0.req_wdata = rwd[0];
  assign b0.rsp_ready = rr[0];
  assign b1.req_valid = rv[1];
  assign b1.req_we = rwe[1];
  assign b1.req_addr = ra[1];
  assign b1.req_wdata = rwd[1];
  assign b1.rsp_ready = rr[1];
  assign qrdy[0] = b0.req_ready;
  assign qval[0] = b0.rsp_valid;
  assign qwe[0] = b0.rsp_we;
  assign qdata[0] = b0.rsp_data;
  assign qrdy[1] = b1.req_ready;
  assign qval[1] = b1.rsp_valid;
  assign qwe[1] = b1.rsp_we;
  assign qdata[1] = b1.rsp_data;
  mem_responder #(.DATA_W(16), .ADDR_W(4), .LATENCY(2)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave), .busy(qbusy[0]));
  mem_responder #(.DATA_W(16), .ADDR_W(4), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave), .busy(qbusy[1]));

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
`ifdef MEM_RESPONDER_CLEAR_EN
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (qrdy[0] !== 1'b0 || qbusy[0] !== 1'b1) begin
        fails++;
        $display("FAIL clear_busy cycle=%0d got ready=%b busy=%b want ready=0 busy=1", i, qrdy[0], qbusy[0]);
      end
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 16; a++) begin
        model[d][a] = '0;
        known[d][a] = 1'b1;
      end
`endif
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (qrdy[d] !== 1'b1 || qval[d] !== 1'b0 || qbusy[d] !== 1'b0 || qdata[d] !== 16'h0000 || qwe[d] !== 1'b0) begin
        fails++;
        $display("FAIL %s d=%0d got ready=%b valid=%b busy=%b data=%h we=%b want ready=1 valid=0 busy=0 data=0000 we=0",
                 tag, d, qrdy[d], qval[d], qbusy[d], qdata[d], qwe[d]);
      end
    end
  endtask

  // One full transaction; called and returns at a falling edge, accept edge index in t0.
  task automatic xact(input int d, input bit we, input logic [3:0] a, input logic [15:0] wd, input int hold, output int t0);
    int n = 0;
    bit dchk;
    logic [15:0] exp;
    while (qrdy[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (qrdy[d] !== 1'b1) begin
      fails++;
      $display("FAIL ready_timeout d=%0d got ready=%b want 1", d, qrdy[d]);
    end
    rv[d] = 1'b1; rwe[d] = we; ra[d] = a; rwd[d] = wd; rr[d] = (hold == 0);
    @(negedge clk);
    t0 = cyc;
    rv[d] = 1'b0; rwe[d] = 1'($urandom); ra[d] = 4'($urandom); rwd[d] = 16'($urandom);
    dchk = we || known[d][a];
    exp = we ? wd : model[d][a];
    if (we) begin
      model[d][a] = wd;
      known[d][a] = 1'b1;
    end
    for (int k = 0; k < lat[d]; k++) begin
      checks++;
      if (qval[d] !== 1'b0 || qrdy[d] !== 1'b0 || qbusy[d] !== 1'b1) begin
        fails++;
        $display("FAIL wait d=%0d k=%0d got valid=%b ready=%b busy=%b want valid=0 ready=0 busy=1", d, k, qval[d], qrdy[d], qbusy[d]);
      end
      @(negedge clk);
    end
    checks++;
    if (qval[d] !== 1'b1 || qwe[d] !== we || (dchk && qdata[d] !== exp)) begin
      fails++;
      $display("FAIL rsp d=%0d addr=%h got valid=%b we=%b data=%h want valid=1 we=%b data=%h", d, a, qval[d], qwe[d], qdata[d], we, exp);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (qval[d] !== 1'b1 || qrdy[d] !== 1'b0 || qwe[d] !== we || (dchk && qdata[d] !== exp)) begin
        fails++;
        $display("FAIL hold d=%0d h=%0d got valid=%b ready=%b data=%h want valid=1 ready=0 data=%h", d, h, qval[d], qrdy[d], qdata[d], exp);
      end
    end
    rr[d] = 1'b1;
    @(negedge clk);
    rr[d] = 1'b0;
    checks++;
    if (qval[d] !== 1'b0 || qrdy[d] !== 1'b1) begin
      fails++;
      $display("FAIL handshake d=%0d got valid=%b ready=%b want valid=0 ready=1", d, qval[d], qrdy[d]);
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    check_idle("reset_idle");
  endtask

  task automatic test_write_read();
    int t;
    xact(0, 1'b1, 4'h3, 16'hA5C3, 0, t);
    xact(0, 1'b0, 4'h3, 16'h0000, 0, t);
  endtask

  task automatic test_backpressure();
    int t;
    xact(0, 1'b1, 4'h7, 16'($urandom), 0, t);
    xact(0, 1'b0, 4'h7, 16'h0000, 5, t);
  endtask

  task automatic test_reset_mid_write();
    int t;
    xact(0, 1'b1, 4'h1, 16'($urandom) ^ 16'h8000, 0, t);
    rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = 4'h1; rwd[0] = 16'h1234;
    @(negedge clk);
    rv[0] = 1'b0;
    do_reset(1);
    check_idle("reset_mid");
    xact(0, 1'b0, 4'h1, 16'h0000, 0, t);
  endtask

  task automatic test_random();
    int t;
    for (int i = 0; i < 40; i++)
      xact(0, 1'($urandom), 4'($urandom), 16'($urandom), int'($urandom_range(0, 2)), t);
  endtask

  task automatic test_back_to_back();
    int t, tp;
    for (int pass = 0; pass < 2; pass++)
      for (int k = 0; k < 16; k++) begin
        xact(1, pass == 0, 4'(k), 16'h0100 + 16'(k), 0, t);
        if (k > 0) begin
          checks++;
          if (t - tp !== 3) begin
            fails++;
            $display("FAIL b2b_spacing pass=%0d k=%0d got %0d cycles want 3", pass, k, t - tp);
          end
        end
        tp = t;
      end
  endtask

`ifdef MEM_RESPONDER_CLEAR_EN
  task automatic test_clear();
    int t;
    xact(0, 1'b1, 4'hF, 16'hFFFF, 0, t);
    do_reset(1);
    xact(0, 1'b0, 4'hF, 16'h0000, 0, t);
  endtask
`endif

  initial begin
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rwe[d] = 1'b0; ra[d] = '0; rwd[d] = '0; rr[d] = 1'b0;
      for (int a = 0; a < 16; a++) known[d][a] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_backpressure();
    test_reset_mid_write();
    test_random();
    test_back_to_back();
`ifdef MEM_RESPONDER_CLEAR_EN
    test_clear();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed memory target that answers read and write requests from a processor-side initiator, such as mem_controller's instruction and operand fetch.
- Holds a 2^ADDR_W x DATA_W storage array.
- Serves one request at a time over a valid/ready request channel and a valid/ready response channel.
- Access latency is fixed and configurable, so the initiator's stall handling can be exercised.

Parameters:
- DATA_W, 16, width of a memory word and of the instruction/data bus.
- ADDR_W, 4, address width; depth is 2^ADDR_W words.
- LATENCY, 2, number of clock edges from request accept to response valid; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data; ignored for reads.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator takes the response.
- rsp_data  output  DATA_W  read data, or an echo of the written data for writes.
- rsp_we  output  1  copy of req_we for the current response.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- States are IDLE, WAIT and RESP.
- Reset, applied while reset=0 at a clock edge:
  - state=IDLE, cnt=0, rsp_valid=0, rsp_data=0, rsp_we=0, busy=0.
  - Storage contents are not altered (see Optional Feature).
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch req_addr, req_we and req_wdata, set cnt=LATENCY, and go to WAIT.
- WAIT:
  - req_ready=0.
  - Each edge decrements cnt.
  - On the edge where cnt==1, the access is performed:
    - Write: mem[addr] <= wdata and rsp_data <= wdata.
    - Read: rsp_data <= mem[addr].
  - Also on that edge: rsp_we <= latched we, and go to RESP.
- Latency: for a request accepted at edge E0, rsp_valid is high after edge E0+LATENCY.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_data and rsp_we are held stable until the handshake.
  - On an edge with rsp_ready=1, rsp_valid <= 0 and go to IDLE.
  - The earliest next accept is the following edge.
- Throughput: at most one transaction per LATENCY+2 cycles; requests are never pipelined.
- A read of an address written by the previous transaction returns the new data; there is no read-during-write hazard, because accesses are serialised.
- rsp_ready asserted while rsp_valid=0 is ignored.
- req_valid while req_ready=0 is ignored; the initiator must hold the request until it is accepted.
- Reset mid-operation:
  - Reset in WAIT before the access edge: no memory write occurs.
  - Reset in RESP: the response is discarded and storage is unchanged.
- Address wrap: req_addr is used as-is; there is no out-of-range case.

Optional Feature:
- Macro: MEM_RESPONDER_CLEAR_EN.
- Defined:
  - Reset additionally enters a CLEAR state.
  - After reset deasserts, the block writes 0 to mem[0], mem[1], ... mem[2^ADDR_W-1], one word per edge.
  - req_ready=0 and busy=1 throughout CLEAR; after the last word it goes to IDLE.
  - First accept is possible 2^ADDR_W edges after reset release.
  - Reasserting reset during CLEAR restarts the sweep at address 0.
- Undefined: there is no CLEAR state, storage survives reset, and req_ready=1 on the first cycle after reset release.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> req_ready=1, rsp_valid=0, rsp_data=16'h0000, busy=0.
- Write then read, LATENCY=2:
  - Write addr 4'h3, data 16'hA5C3, accepted at E0 -> rsp_valid after E2 with rsp_data=16'hA5C3, rsp_we=1.
  - Then read addr 4'h3 -> rsp_data=16'hA5C3, rsp_we=0, valid 2 edges after accept.
- Response backpressure: read addr 4'h7 with rsp_ready=0 for 5 cycles -> rsp_valid stays 1, rsp_data stable, req_ready=0; raise rsp_ready -> rsp_valid=0 and req_ready=1 on the next cycle.
- Reset mid-write: write addr 4'h1 data 16'h1234, assert reset one edge after accept (LATENCY=2), then read addr 4'h1 -> prior contents are returned, not 16'h1234.
- Back-to-back with LATENCY=1: write 16 words (addr k, data 16'h0100+k), then read them all with rsp_ready held 1 -> each read returns 16'h0100+k; one transaction every 3 cycles.
- With MEM_RESPONDER_CLEAR_EN: write addr 4'hF data 16'hFFFF, then reset -> req_ready=0 for 16 cycles, and a subsequent read of addr 4'hF returns 16'h0000.
